dmuxn_reg: RTL and testbench
============================

Name: dmuxn_reg

Overview:
- Parametrised, registered N-way demultiplexer; successor to the fixed 8-way combinational dmux8.
- Routes one W-bit word per transfer from a single valid/ready source to one of N valid/ready sinks, selected by address.
- Used for Hack CPU bus fan-out: RAM banks, screen, keyboard and I/O ports.
- Holds one word in an output register. Latency is 1 cycle and throughput is 1 word per cycle.

Parameters:
- N, 8, number of output channels (2..256; need not be a power of 2).
- W, 16, data word width in bits.
- AW, $clog2(N), address width. Derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source has a word
- in_ready  out  1  block can accept a word this cycle
- in_addr  in  AW  target channel index
- in_data  in  W  word to route
- in_bcast  in  1  broadcast request (see Optional Feature)
- out_valid  out  N  one-hot (or all-ones in broadcast) per-channel valid
- out_ready  in  N  per-channel sink ready
- out_data  out  W  shared registered data, meaningful where out_valid bit is set
- addr_err  out  1  one-cycle pulse: last accepted word had in_addr >= N and was dropped

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_data=0, addr_err=0, state EMPTY.
- Definitions:
  - accept = in_valid & in_ready.
  - drain = every set out_valid bit has its out_ready set this cycle.
- in_ready = (state==EMPTY) | drain. This is a combinational path from out_ready; no path from in_valid.
- State EMPTY:
  - On accept with in_addr < N: out_valid <= (1<<in_addr), out_data <= in_data, go FULL.
  - On accept with in_addr >= N: word dropped, addr_err <= 1 for one cycle, stay EMPTY, out_data unchanged.
- State FULL:
  - Hold out_valid and out_data stable until each set bit handshakes.
  - On drain without accept: out_valid <= 0, go EMPTY; out_data holds its last value.
  - On drain with a valid accept: load the new word in the same edge and stay FULL. No bubble.
  - On drain with an out-of-range accept: go EMPTY and pulse addr_err.
- out_ready bits whose out_valid is 0 are ignored.
- addr_err is 0 in every cycle not immediately following an out-of-range accept.
- Reset asserted mid-transfer discards the held word immediately (asynchronously). No partial outputs.
- The in_addr value is only sampled on accept; X on in_addr while in_valid=0 has no effect.

Optional Feature:
- Macro: DMUX_BCAST_EN.
- Defined:
  - Accept with in_bcast=1 sets out_valid to all-ones (N bits) and loads out_data; in_addr is ignored.
  - Each bit clears individually on its own handshake.
  - The block stays FULL until all bits clear.
  - Drain (and same-cycle reload) occurs on the cycle the last remaining bits handshake.
  - addr_err is never raised for a broadcast.
- Undefined: in_bcast is ignored; every transfer is unicast per in_addr. The port is still present so the interface is identical in both builds.

Test Plan:
- Reset release, then N=8, W=16: send addr=0..7, data=16'h1000+addr, out_ready=8'hFF -> out_valid=(1<<addr) exactly one cycle after each accept; out_data matches; in_ready held 1 throughout (back-to-back, 8 words in 8 cycles).
- Backpressure: send addr=3 data=16'hBEEF with out_ready=0 for 5 cycles -> out_valid=8'h08 and out_data=16'hBEEF stable, in_ready=0; raise out_ready[3] -> in_ready=1 that cycle, and a queued word (addr=5) loads with no bubble.
- Ignored readies: word held on ch2 with out_ready=8'hFB -> stays FULL (non-selected readies have no effect).
- Out-of-range: N=6, addr=7 data=16'h1234 -> no out_valid bit set, addr_err=1 for exactly one cycle, in_ready stays 1; a following addr=1 transfer proceeds normally.
- Async reset: hold a word on ch6, pulse rst_n low mid-cycle -> out_valid=0 and out_data=0 without waiting for a clk edge; in_ready=1 after release.
- DMUX_BCAST_EN: bcast=1 data=16'hA5A5 -> out_valid=8'hFF; handshake ch0..3, then ch4..7 two cycles later -> bits clear in two groups, in_ready=1 only on the final group's cycle. Without the macro, the same stimulus with addr=2 -> out_valid=8'h04.

Source files
------------

// File: rtl/dmuxn_reg.sv
// rtl/dmuxn_reg.sv - registered N-way valid/ready demultiplexer (optional broadcast via DMUX_BCAST_EN)
module dmuxn_reg #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] in_addr,
    input  logic [W-1:0]                      in_data,
    input  logic                              in_bcast,
    output logic [N-1:0]                      out_valid,
    input  logic [N-1:0]                      out_ready,
    output logic [W-1:0]                      out_data,
    output logic                              addr_err
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0] N_L = (AW + 1)'(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   valid_n;
    logic [W-1:0]   data_n;
    logic           err_n;
    logic           drain;
    logic           accept;
    logic           addr_ok;
    logic           is_bcast;
    logic [N-1:0]   onehot;

`ifdef DMUX_BCAST_EN
    assign is_bcast = in_bcast;
`else
    // Broadcast disabled: the port stays on the interface but has no effect.
    logic unused_bcast;
    assign unused_bcast = in_bcast;
    assign is_bcast     = 1'b0;
`endif

    // Drain means no set valid bit is still waiting on its sink.
    assign drain    = ~|(out_valid & ~out_ready);
    assign in_ready = (state == EMPTY) | drain;
    assign accept   = in_valid & in_ready;
    assign addr_ok  = {1'b0, in_addr} < N_L;
    assign onehot   = {{(N-1){1'b0}}, 1'b1} << in_addr;

    // Next-state and next-output selection.
    always_comb begin
        state_n = state;
        valid_n = out_valid;
        data_n  = out_data;
        err_n   = 1'b0;
        if (state == FULL) begin
            if (drain) begin
                valid_n = '0;
                state_n = EMPTY;
            end else begin
                // Bits that handshook clear individually; others keep waiting.
                valid_n = out_valid & ~out_ready;
            end
        end
        if (accept) begin
            if (is_bcast) begin
                valid_n = '1;
                data_n  = in_data;
                state_n = FULL;
            end else if (addr_ok) begin
                valid_n = onehot;
                data_n  = in_data;
                state_n = FULL;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    // State and output registers; reset discards any held word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= '0;
            out_data  <= '0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            addr_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_dmuxn_reg.sv
// tb/tb_dmuxn_reg.sv - self-checking bench for dmuxn_reg (N=8 directed, N=6 randomized)
module tb_dmuxn_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic        v8, r8, b8, e8;
    logic [2:0]  a8;
    logic [15:0] d8, od8;
    logic [7:0]  ov8, or8;

    logic        v6, r6, b6, e6;
    logic [2:0]  a6;
    logic [15:0] d6, od6;
    logic [5:0]  ov6, or6;

    always #5 clk = ~clk;

    dmuxn_reg #(.N(8), .W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_addr(a8),
        .in_data(d8), .in_bcast(b8), .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .addr_err(e8)
    );

    dmuxn_reg #(.N(6), .W(16)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_addr(a6),
        .in_data(d6), .in_bcast(b6), .out_valid(ov6), .out_ready(or6),
        .out_data(od6), .addr_err(e6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL reset_valid8 got %h want 00", ov8); end
        checks++; if (od8 !== 16'h0) begin errors++; $display("FAIL reset_data8 got %h want 0000", od8); end
        checks++; if (e8 !== 1'b0) begin errors++; $display("FAIL reset_err8 got %b want 0", e8); end
        checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL reset_ready8 got %b want 1", r8); end
        checks++; if (ov6 !== 6'h00) begin errors++; $display("FAIL reset_valid6 got %h want 00", ov6); end
        checks++; if (r6 !== 1'b1) begin errors++; $display("FAIL reset_ready6 got %b want 1", r6); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_v;
        or8 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            v8 = 1'b1; a8 = 3'(i); d8 = 16'h1000 + 16'(i);
            #1;
            checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, r8); end
            step();
            exp_v = 8'h01 << i;
            checks++; if (ov8 !== exp_v) begin errors++; $display("FAIL stream_valid[%0d] got %h want %h", i, ov8, exp_v); end
            checks++; if (od8 !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, od8, 16'h1000 + 16'(i)); end
        end
        v8 = 1'b0;
        step();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL stream_drain got %h want 00", ov8); end
    endtask

    task automatic test_backpressure();
        or8 = 8'h00; v8 = 1'b1; a8 = 3'd3; d8 = 16'hBEEF;
        step();
        v8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ov8 !== 8'h08 || od8 !== 16'hBEEF || r8 !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%h d=%h r=%b want v=08 d=beef r=0", i, ov8, od8, r8);
            end
            step();
        end
        v8 = 1'b1; a8 = 3'd5; d8 = 16'hCAFE; or8 = 8'h08;
        #1;
        checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", r8); end
        step();
        v8 = 1'b0; or8 = 8'h00;
        checks++; if (ov8 !== 8'h20 || od8 !== 16'hCAFE) begin
            errors++; $display("FAIL bp_nobubble got v=%h d=%h want v=20 d=cafe", ov8, od8);
        end
        or8 = 8'hFF;
        step();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL bp_drain got %h want 00", ov8); end
    endtask

    task automatic test_ignored_ready();
        or8 = 8'h00; v8 = 1'b1; a8 = 3'd2; d8 = 16'h2222;
        step();
        v8 = 1'b0; or8 = 8'hFB;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (r8 !== 1'b0) begin errors++; $display("FAIL ign_ready[%0d] got %b want 0", i, r8); end
            step();
            checks++; if (ov8 !== 8'h04 || od8 !== 16'h2222) begin
                errors++; $display("FAIL ign_hold[%0d] got v=%h d=%h want v=04 d=2222", i, ov8, od8);
            end
        end
        or8 = 8'hFF;
        step();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL ign_drain got %h want 00", ov8); end
    endtask

    task automatic test_out_of_range();
        or6 = 6'h3F; v6 = 1'b1; a6 = 3'd7; d6 = 16'h1234;
        #1;
        checks++; if (r6 !== 1'b1) begin errors++; $display("FAIL oor_ready got %b want 1", r6); end
        step();
        a6 = 3'd1; d6 = 16'h5555;
        checks++; if (ov6 !== 6'h00 || e6 !== 1'b1 || r6 !== 1'b1 || od6 !== 16'h0000) begin
            errors++; $display("FAIL oor_drop got v=%h e=%b r=%b d=%h want v=00 e=1 r=1 d=0000", ov6, e6, r6, od6);
        end
        step();
        v6 = 1'b0;
        checks++; if (ov6 !== 6'h02 || e6 !== 1'b0 || od6 !== 16'h5555) begin
            errors++; $display("FAIL oor_next got v=%h e=%b d=%h want v=02 e=0 d=5555", ov6, e6, od6);
        end
        step();
        checks++; if (ov6 !== 6'h00 || e6 !== 1'b0) begin errors++; $display("FAIL oor_drain got v=%h e=%b want 00 0", ov6, e6); end
        or6 = 6'h00;
    endtask

    task automatic test_async_reset();
        or8 = 8'h00; v8 = 1'b1; a8 = 3'd6; d8 = 16'h6666;
        step();
        v8 = 1'b0;
        checks++; if (ov8 !== 8'h40) begin errors++; $display("FAIL arst_load got %h want 40", ov8); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ov8 !== 8'h00 || od8 !== 16'h0000 || r8 !== 1'b1) begin
            errors++; $display("FAIL arst_clear got v=%h d=%h r=%b want v=00 d=0000 r=1", ov8, od8, r8);
        end
        #2 rst_n = 1'b1;
        step();
        checks++; if (r8 !== 1'b1 || ov8 !== 8'h00) begin errors++; $display("FAIL arst_after got r=%b v=%h want 1 00", r8, ov8); end
    endtask

    task automatic test_bcast();
        or8 = 8'h00; v8 = 1'b1; b8 = 1'b1; a8 = 3'd2; d8 = 16'hA5A5;
        step();
        v8 = 1'b0; b8 = 1'b0;
`ifdef DMUX_BCAST_EN
        checks++; if (ov8 !== 8'hFF || od8 !== 16'hA5A5 || r8 !== 1'b0) begin
            errors++; $display("FAIL bc_load got v=%h d=%h r=%b want v=ff d=a5a5 r=0", ov8, od8, r8);
        end
        or8 = 8'h0F;
        #1;
        checks++; if (r8 !== 1'b0) begin errors++; $display("FAIL bc_ready_grp0 got %b want 0", r8); end
        step();
        or8 = 8'h00;
        checks++; if (ov8 !== 8'hF0) begin errors++; $display("FAIL bc_grp0 got %h want f0", ov8); end
        step();
        checks++; if (ov8 !== 8'hF0 || r8 !== 1'b0) begin errors++; $display("FAIL bc_wait got v=%h r=%b want f0 0", ov8, r8); end
        or8 = 8'hF0;
        #1;
        checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL bc_ready_grp1 got %b want 1", r8); end
        step();
        checks++; if (ov8 !== 8'h00 || e8 !== 1'b0) begin errors++; $display("FAIL bc_drain got v=%h e=%b want 00 0", ov8, e8); end
`else
        checks++; if (ov8 !== 8'h04 || od8 !== 16'hA5A5) begin
            errors++; $display("FAIL nobc_unicast got v=%h d=%h want v=04 d=a5a5", ov8, od8);
        end
        or8 = 8'hFF;
        step();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL nobc_drain got %h want 00", ov8); end
`endif
        or8 = 8'h00;
    endtask

    // Reference: a slot holding the set of channels still owed the word.
    task automatic test_random();
        int m_mask = 0;
        int m_data = 0;
        int m_err  = 0;
        int pending;
        bit m_ready, bc;
        for (int c = 0; c < 400; c++) begin
            v6  = ($urandom_range(0, 3) != 0);
            a6  = 3'($urandom_range(0, 7));
            d6  = 16'($urandom);
            b6  = ($urandom_range(0, 7) == 0);
            or6 = 6'($urandom);
            #1;
            pending = m_mask & ~int'(or6) & 'h3F;
            m_ready = (pending == 0);
            checks++; if (r6 !== m_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", c, r6, m_ready); end
`ifdef DMUX_BCAST_EN
            bc = b6;
`else
            bc = 1'b0;
`endif
            if (v6 && m_ready) begin
                if (bc) begin
                    m_mask = 'h3F; m_data = int'(d6); m_err = 0;
                end else if (int'(a6) < 6) begin
                    m_mask = 1 << a6; m_data = int'(d6); m_err = 0;
                end else begin
                    m_mask = 0; m_err = 1;
                end
            end else begin
                m_mask = pending; m_err = 0;
            end
            step();
            checks++; if (ov6 !== 6'(m_mask) || od6 !== 16'(m_data) || e6 !== 1'(m_err)) begin
                errors++; $display("FAIL rnd_out[%0d] got v=%h d=%h e=%b want v=%h d=%h e=%0d", c, ov6, od6, e6, 6'(m_mask), 16'(m_data), m_err);
            end
        end
        v6 = 1'b0; or6 = 6'h00;
    endtask

    initial begin
        v8 = 0; a8 = 0; d8 = 0; b8 = 0; or8 = 0;
        v6 = 0; a6 = 0; d6 = 0; b6 = 0; or6 = 0;
        #3;
        test_reset();
        #4 rst_n = 1'b1;
        step();
        test_stream();
        test_backpressure();
        test_ignored_ready();
        test_out_of_range();
        test_bcast();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
